// File: rtl/maxnet_mem.sv
// MaxNet storage: serial X loader, row-major (w_ij, x_j) streamer, double-buffered neuron writeback.
// Define WEIGHT_RAM_EN for a writable N*N weight array; otherwise weights are decoded from the diagonal.
module maxnet_mem #(
    parameter int              N      = 4,
    parameter int              WIDTH  = 5,
    parameter logic [WIDTH-1:0] SELF_W = 5'b01000,
    parameter logic [WIDTH-1:0] EPS_W  = 5'b11110,
    localparam int             IW     = $clog2(N),
    localparam int             WIW    = $clog2(N*N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             x_in_valid,
    output logic             x_in_ready,
    input  logic [WIDTH-1:0] x_in_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             s_valid,
    input  logic             s_ready,
    output logic [WIDTH-1:0] s_w,
    output logic [WIDTH-1:0] s_x,
    output logic [IW-1:0]    s_row,
    output logic [IW-1:0]    s_col,
    output logic             s_last_col,
    output logic             s_last,
    input  logic             upd_we,
    input  logic [IW-1:0]    upd_idx,
    input  logic [WIDTH-1:0] upd_data
`ifdef WEIGHT_RAM_EN
    ,
    input  logic             wt_we,
    input  logic [WIW-1:0]   wt_idx,
    input  logic [WIDTH-1:0] wt_data
`endif
);

    typedef enum logic [1:0] {ST_EMPTY, ST_LOADING, ST_READY, ST_STREAM} state_t;

    state_t           state_q;
    logic [IW-1:0]    load_idx_q;
    logic [WIDTH-1:0] x_q      [N];
    logic [WIDTH-1:0] shadow_q [N];
    logic [N-1:0]     mask_q;
    logic             done_q;
    logic             s_valid_q;
    logic [WIDTH-1:0] s_w_q;
    logic [WIDTH-1:0] s_x_q;
    logic [IW-1:0]    s_row_q;
    logic [IW-1:0]    s_col_q;
    logic             s_last_col_q;
    logic             s_last_q;

    logic             load_hs;
    logic             accept;
    logic             upd_ok;
    logic [IW-1:0]    nxt_row_d;
    logic [IW-1:0]    nxt_col_d;
    logic [WIDTH-1:0] w_nxt_d;

    assign x_in_ready = (state_q == ST_EMPTY) || (state_q == ST_LOADING);
    assign busy       = (state_q == ST_STREAM);
    assign done       = done_q;
    assign s_valid    = s_valid_q;
    assign s_w        = s_w_q;
    assign s_x        = s_x_q;
    assign s_row      = s_row_q;
    assign s_col      = s_col_q;
    assign s_last_col = s_last_col_q;
    assign s_last     = s_last_q;

    assign load_hs = x_in_valid && x_in_ready;
    assign accept  = s_valid_q && s_ready;

    // Out-of-range indices only exist when N is not a power of two.
    generate
        if ((1 << IW) == N) begin : g_upd_full
            assign upd_ok = 1'b1;
        end else begin : g_upd_part
            assign upd_ok = (int'(upd_idx) < N);
        end
    endgenerate

    // Next beat pointer: (0,0) when launching from READY, otherwise row-major advance.
    always_comb begin
        nxt_row_d = '0;
        nxt_col_d = '0;
        if (state_q != ST_READY) begin
            if (s_col_q == IW'(N-1)) begin
                nxt_row_d = s_row_q + 1'b1;
            end else begin
                nxt_row_d = s_row_q;
                nxt_col_d = s_col_q + 1'b1;
            end
        end
    end

`ifdef WEIGHT_RAM_EN
    logic [WIDTH-1:0] w_q [N*N];
    logic [WIW-1:0]   w_addr_d;
    logic             wt_ok;

    assign w_addr_d = WIW'(int'(nxt_row_d) * N + int'(nxt_col_d));
    assign w_nxt_d  = w_q[w_addr_d];

    generate
        if ((1 << WIW) == N*N) begin : g_wt_full
            assign wt_ok = 1'b1;
        end else begin : g_wt_part
            assign wt_ok = (int'(wt_idx) < N*N);
        end
        for (genvar gi = 0; gi < N*N; gi++) begin : g_w
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    w_q[gi] <= ((gi / N) == (gi % N)) ? SELF_W : EPS_W;
                else if (wt_we && wt_ok && (state_q != ST_STREAM) && (wt_idx == WIW'(gi)))
                    w_q[gi] <= wt_data;
            end
        end
    endgenerate
`else
    assign w_nxt_d = (nxt_row_d == nxt_col_d) ? SELF_W : EPS_W;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            load_idx_q   <= '0;
            mask_q       <= '0;
            done_q       <= 1'b0;
            s_valid_q    <= 1'b0;
            s_w_q        <= '0;
            s_x_q        <= '0;
            s_row_q      <= '0;
            s_col_q      <= '0;
            s_last_col_q <= 1'b0;
            s_last_q     <= 1'b0;
            for (int i = 0; i < N; i++) begin
                x_q[i]      <= '0;
                shadow_q[i] <= '0;
            end
        end else if (clear) begin
            state_q      <= ST_EMPTY;
            load_idx_q   <= '0;
            mask_q       <= '0;
            done_q       <= 1'b0;
            s_valid_q    <= 1'b0;
            s_w_q        <= '0;
            s_x_q        <= '0;
            s_row_q      <= '0;
            s_col_q      <= '0;
            s_last_col_q <= 1'b0;
            s_last_q     <= 1'b0;
            for (int i = 0; i < N; i++) begin
                x_q[i]      <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_EMPTY, ST_LOADING: begin
                    if (load_hs) begin
                        x_q[load_idx_q] <= x_in_data;
                        if (load_idx_q == IW'(N-1)) begin
                            load_idx_q <= '0;
                            state_q    <= ST_READY;
                        end else begin
                            load_idx_q <= load_idx_q + 1'b1;
                            state_q    <= ST_LOADING;
                        end
                    end
                end
                ST_READY: begin
                    if (upd_we && upd_ok)
                        x_q[upd_idx] <= upd_data;
                    if (start) begin
                        state_q      <= ST_STREAM;
                        s_valid_q    <= 1'b1;
                        s_row_q      <= nxt_row_d;
                        s_col_q      <= nxt_col_d;
                        s_x_q        <= x_q[nxt_col_d];
                        s_w_q        <= w_nxt_d;
                        s_last_col_q <= (nxt_col_d == IW'(N-1));
                        s_last_q     <= (nxt_col_d == IW'(N-1)) && (nxt_row_d == IW'(N-1));
                    end
                end
                ST_STREAM: begin
                    if (upd_we && upd_ok) begin
                        shadow_q[upd_idx] <= upd_data;
                        mask_q[upd_idx]   <= 1'b1;
                    end
                    if (accept) begin
                        if (s_last_q) begin
                            // Atomic commit; a writeback in this same cycle bypasses the shadow.
                            for (int i = 0; i < N; i++)
                                if (mask_q[i])
                                    x_q[i] <= shadow_q[i];
                            if (upd_we && upd_ok)
                                x_q[upd_idx] <= upd_data;
                            mask_q    <= '0;
                            state_q   <= ST_READY;
                            s_valid_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            s_row_q      <= nxt_row_d;
                            s_col_q      <= nxt_col_d;
                            s_x_q        <= x_q[nxt_col_d];
                            s_w_q        <= w_nxt_d;
                            s_last_col_q <= (nxt_col_d == IW'(N-1));
                            s_last_q     <= (nxt_col_d == IW'(N-1)) && (nxt_row_d == IW'(N-1));
                        end
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

endmodule
